// File: rtl/vga_pkg.sv
// Shared VGA adapter constants, sequencer state encoding and colour names.
// The on_screen helper decides whether a wrapped coordinate is visible.
package vga_pkg;

    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COLOUR_W = 3;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [COLOUR_W-1:0] BLACK = 3'b000;
    localparam logic [COLOUR_W-1:0] WHITE = 3'b111;

    function automatic logic on_screen(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
        return (int'(x) < SCREEN_W) && (int'(y) < SCREEN_H);
    endfunction

endpackage

// File: rtl/rect_fill_ctrl_if.sv
// Command handshake plus VGA plot port of the rectangle-fill sequencer.
// master drives commands and watches pixels; slave is the sequencer.
interface rect_fill_ctrl_if;
    import vga_pkg::*;

    logic                cmd_valid;
    logic                cmd_ready;
    logic [X_W-1:0]      cmd_x;
    logic [Y_W-1:0]      cmd_y;
    logic [X_W-1:0]      cmd_w;
    logic [Y_W-1:0]      cmd_h;
    logic [COLOUR_W-1:0] cmd_colour;
    logic [X_W-1:0]      vga_x;
    logic [Y_W-1:0]      vga_y;
    logic [COLOUR_W-1:0] vga_colour;
    logic                vga_plot;
    logic                busy;
    logic                done;

    modport master (
        output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_colour,
        input  cmd_ready, vga_x, vga_y, vga_colour, vga_plot, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_colour,
        output cmd_ready, vga_x, vga_y, vga_colour, vga_plot, busy, done
    );

endinterface

// File: rtl/rect_scan_counter.sv
// Row-major col/row counter for a w x h sweep; exposes next-cycle position for
// registered address generation and flags the last pixel of the rectangle.
module rect_scan_counter
    import vga_pkg::*;
(
    input  logic           clock,
    input  logic           reset,
    input  logic           load_i,
    input  logic           en_i,
    input  logic [X_W-1:0] w_i,
    input  logic [Y_W-1:0] h_i,
    output logic [X_W-1:0] col_nxt_o,
    output logic [Y_W-1:0] row_nxt_o,
    output logic           last_o
);

    logic [X_W-1:0] col_q, col_d, w_q, w_d;
    logic [Y_W-1:0] row_q, row_d, h_q, h_d;
    logic           col_wrap;

    assign col_wrap = (col_q == w_q - X_W'(1));

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        w_d   = w_q;
        h_d   = h_q;
        if (load_i) begin
            col_d = '0;
            row_d = '0;
            w_d   = w_i;
            h_d   = h_i;
        end else if (en_i) begin
            if (col_wrap) begin
                col_d = '0;
                row_d = row_q + Y_W'(1);
            end else begin
                col_d = col_q + X_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            col_q <= '0;
            row_q <= '0;
            w_q   <= '0;
            h_q   <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            w_q   <= w_d;
            h_q   <= h_d;
        end
    end

    assign col_nxt_o = col_d;
    assign row_nxt_o = row_d;
    assign last_o    = col_wrap && (row_q == h_q - Y_W'(1));

endmodule

// File: rtl/rect_fill_ctrl.sv
// Rectangle-fill sequencer: one pixel per clock, row-major; DRAW_CLIP_EN masks off-screen plots.
// First plot the cycle after accept; cmd_ready only in IDLE, so commands wait through DRAW/DONE.
module rect_fill_ctrl
    import vga_pkg::*;
(
    input  logic           clock,
    input  logic           reset,
    rect_fill_ctrl_if.slave bus
);

    state_t              state_q, state_d;
    logic [X_W-1:0]      x0_q, x0_d;
    logic [Y_W-1:0]      y0_q, y0_d;
    logic [X_W-1:0]      vga_x_q, vga_x_d;
    logic [Y_W-1:0]      vga_y_q, vga_y_d;
    logic [COLOUR_W-1:0] vga_colour_q, vga_colour_d;
    logic                vga_plot_q, vga_plot_d;
    logic                plot_pix;

    logic           cnt_load, cnt_en, cnt_last;
    logic [X_W-1:0] col_nxt;
    logic [Y_W-1:0] row_nxt;

    // Kept outside the comb block so the counter's next-value path is not a loop.
    assign cnt_load = (state_q == IDLE) && bus.cmd_valid;
    assign cnt_en   = (state_q == DRAW) && !cnt_last;

    rect_scan_counter u_scan (
        .clock     (clock),
        .reset     (reset),
        .load_i    (cnt_load),
        .en_i      (cnt_en),
        .w_i       (bus.cmd_w),
        .h_i       (bus.cmd_h),
        .col_nxt_o (col_nxt),
        .row_nxt_o (row_nxt),
        .last_o    (cnt_last)
    );

    always_comb begin
        state_d      = state_q;
        x0_d         = x0_q;
        y0_d         = y0_q;
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_colour_d = vga_colour_q;
        plot_pix     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    x0_d         = bus.cmd_x;
                    y0_d         = bus.cmd_y;
                    vga_x_d      = bus.cmd_x;
                    vga_y_d      = bus.cmd_y;
                    vga_colour_d = bus.cmd_colour;
                    if ((bus.cmd_w != '0) && (bus.cmd_h != '0)) begin
                        state_d  = DRAW;
                        plot_pix = 1'b1;
                    end else begin
                        state_d  = DONE;
                    end
                end
            end
            DRAW: begin
                if (cnt_last) begin
                    state_d = DONE;
                end else begin
                    vga_x_d  = x0_q + col_nxt;
                    vga_y_d  = y0_q + row_nxt;
                    plot_pix = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
`ifdef DRAW_CLIP_EN
        vga_plot_d = plot_pix && on_screen(vga_x_d, vga_y_d);
`else
        vga_plot_d = plot_pix;
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            x0_q         <= '0;
            y0_q         <= '0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= BLACK;
            vga_plot_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            x0_q         <= x0_d;
            y0_q         <= y0_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            vga_plot_q   <= vga_plot_d;
        end
    end

    assign bus.cmd_ready  = (state_q == IDLE);
    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = (state_q == DONE);
    assign bus.vga_x      = vga_x_q;
    assign bus.vga_y      = vga_y_q;
    assign bus.vga_colour = vga_colour_q;
    assign bus.vga_plot   = vga_plot_q;

endmodule

// File: doc/rect_fill_ctrl.md
# rect_fill_ctrl

Sequencer in front of the 160x120, 3-bit-colour VGA adapter's plot port. Accepts one rectangle-fill command at a time over a valid/ready handshake, then sweeps it row-major, emitting one pixel (x, y, colour, plot) per clock. It lets the start-screen and game logic draw filled boxes (backgrounds, sprites, clears) without hand-sequencing pixel writes. Output registers connect directly to the adapter's x/y/colour/plot inputs.

## Interface
- X_W, 8, pixel x coordinate width
- Y_W, 7, pixel y coordinate width
- COLOUR_W, 3, colour width (1 bit per channel)
- SCREEN_W, 160, visible columns
- SCREEN_H, 120, visible rows
- clock  in  1  system clock (50 MHz); single clock domain
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_x  in  X_W  top-left column
- cmd_y  in  Y_W  top-left row
- cmd_w  in  X_W  width in pixels (0 allowed)
- cmd_h  in  Y_W  height in pixels (0 allowed)
- cmd_colour  in  COLOUR_W  fill colour
- vga_x  out  X_W  pixel column to adapter
- vga_y  out  Y_W  pixel row to adapter
- vga_colour  out  COLOUR_W  pixel colour to adapter
- vga_plot  out  1  write strobe to adapter, active high
- busy  out  1  high in DRAW and DONE
- done  out  1  one-cycle pulse when a command completes

## Operation
- States: IDLE, DRAW, DONE.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch x0, y0, w, h, colour; clear col/row counters. Go to DRAW if w!=0 and h!=0, else go straight to DONE (no plot cycles).
- DRAW: each cycle presents vga_x=x0+col, vga_y=y0+row (computed in X_W/Y_W bits, modulo 2^width), vga_colour=latched colour, vga_plot=1. col increments; when col==w-1, col<=0 and row increments. When col==w-1 and row==h-1, go to DONE.
- DONE: done=1 for exactly one cycle, vga_plot=0, cmd_ready=0; next state IDLE.
- cmd_* inputs are ignored outside the accept cycle; changing them mid-draw has no effect.
- Pixel order strictly row-major, left to right, top to bottom.
- Reset values: state IDLE, cmd_ready=1 (first cycle after reset released), vga_plot=0, done=0, busy=0, vga_x=0, vga_y=0, vga_colour=0.
- Reset mid-DRAW: aborts immediately; no done pulse; remaining pixels never plotted.

## Timing
- Command accepted at edge N -> first vga_plot=1 cycle is N+1 (outputs registered).
- Exactly w*h consecutive vga_plot cycles, no bubbles.
- done asserted in the cycle after the last plot; cmd_ready high again the cycle after done.
- Command-to-command minimum spacing: w*h+2 cycles; zero-size command: 2 cycles (accept -> DONE -> IDLE).
- Max w*h = 255*127 cycles; counters sized X_W and Y_W, no overflow.

## Configuration
- DRAW_CLIP_EN defined: pixels whose computed vga_x>=SCREEN_W or vga_y>=SCREEN_H (including coordinate wraparound) are presented with vga_plot=0; cycle count and done timing unchanged.
- DRAW_CLIP_EN undefined: every pixel plotted with vga_plot=1; off-screen coordinates passed through wrapped modulo 2^width (adapter behaviour for them is undefined, caller's responsibility).

## Structure
- Shared package vga_pkg: SCREEN_W, SCREEN_H, X_W, Y_W, COLOUR_W constants; state enum typedef {IDLE, DRAW, DONE}; colour constants (BLACK=3'b000, WHITE=3'b111).
- One sub-module, rect_scan_counter: col/row counter pair with load, enable, and last-pixel flag; the FSM and output registers stay in rect_fill_ctrl.

## Test plan
- Reset held 3 cycles then released -> cmd_ready=1, vga_plot=0, done=0, busy=0.
- cmd (x=10,y=20,w=3,h=2,colour=3'b100) -> 6 plot cycles starting next cycle: (10,20),(11,20),(12,20),(10,21),(11,21),(12,21), colour 100; done one cycle later; cmd_ready back after that.
- cmd w=0,h=5 -> no plot cycles, done 1 cycle after accept, cmd_ready 2 cycles after accept.
- With DRAW_CLIP_EN: cmd (x=158,y=119,w=4,h=2) -> 8 cycles; plot=1 only for (158,119),(159,119); done timing identical. Without macro: all 8 plotted.
- Reset asserted after 3 of 20 pixels of a draw -> vga_plot=0 next cycle, no done pulse, cmd_ready=1 after release; new command proceeds normally.
- Back-to-back: cmd_valid held high with two commands (1x1 then 2x1) -> second accepted exactly 1 cycle after first's done; pixel stream contains no extra or dropped plots.
